mips_mem_arbiter: RTL

Single-port memory arbiter and sequencer for the MIPS32 core. It shares one 2^AW x 32 memory array between the instruction-fetch stage, the data-memory (load/store) stage, and a host load/debug port. The host port is used for program and data preload and for result readback. The block sits between the core pipeline and the memory macro and runs a small FSM that issues one access at a time and returns read data after the memory's fixed latency.

---
 rtl/mips_mem_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port 2^AW x DW memory between the
// instruction fetch stage, the load/store stage and a host load/debug port.
// Issues one access at a time and returns read data after MEM_LAT cycles.
//
// Ports
//   clk1, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr -> if_gnt/if_rvalid          fetch (always read)
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_rvalid
//   host_req/host_we/host_addr/host_wdata -> host_gnt/host_rvalid
//   halted                           core halted; host is only served when 1
//   rd_data                          shared read data, qualified by *_rvalid
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory macro port
//   busy                             FSM not idle
//
// Build option: define MEM_ARB_RR_EN for round-robin between dm and if;
// otherwise dm has fixed priority over if.

module mips_mem_arbiter #(
   parameter int unsigned AW      = 10,
   parameter int unsigned DW      = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   input  logic          halted,
   output logic [DW-1:0] rd_data,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int unsigned   CW        = 2;
   localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_LAT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_DM, SRC_HOST} src_e;

   state_e        state_q, state_d;
   src_e          src_q, src_d;
   src_e          win_c;
   logic          launch_c;
   logic          pick_dm_c;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          we_q, we_d;
   logic          en_q, en_d;
   logic [2:0]    gnt_q, gnt_d;       // {host, dm, if}
   logic [2:0]    rvalid_q, rvalid_d; // {host, dm, if}
   logic          busy_q, busy_d;

   function automatic logic [2:0] src_oh(input src_e s);
      case (s)
         SRC_IF:   src_oh = 3'b001;
         SRC_DM:   src_oh = 3'b010;
         SRC_HOST: src_oh = 3'b100;
         default:  src_oh = 3'b000;
      endcase
   endfunction

`ifdef MEM_ARB_RR_EN
   // Set when fetch was the last core requester granted; resets to favour dm.
   logic last_if_q;

   always_ff @(posedge clk1) begin
      if (!rst_n)                           last_if_q <= 1'b1;
      else if (launch_c && win_c == SRC_DM) last_if_q <= 1'b0;
      else if (launch_c && win_c == SRC_IF) last_if_q <= 1'b1;
   end

   assign pick_dm_c = dm_req & (~if_req | last_if_q);
`else
   assign pick_dm_c = dm_req;
`endif

   // Winner among current request levels; host only counts while halted.
   always_comb begin
      win_c = SRC_NONE;
      if (host_req && halted) win_c = SRC_HOST;
      else if (pick_dm_c)     win_c = SRC_DM;
      else if (if_req)        win_c = SRC_IF;
   end

   // Next state, request latch and registered output values.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      we_d      = 1'b0;
      launch_c  = 1'b0;
      rvalid_d  = 3'b000;

      case (state_q)
         IDLE: launch_c = (win_c != SRC_NONE);
         ISSUE: begin
            if (we_q) begin
               // Writes finish here; chain straight into the next access.
               state_d  = IDLE;
               launch_c = (win_c != SRC_NONE);
            end else begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (cnt_q == LAST_WAIT) begin
               state_d   = RESP;
               rd_data_d = mem_rdata;
               rvalid_d  = src_oh(src_q);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            state_d  = IDLE;
            launch_c = (win_c != SRC_NONE);
         end
         default: state_d = IDLE;
      endcase

      if (launch_c) begin
         state_d = ISSUE;
         src_d   = win_c;
         case (win_c)
            SRC_HOST: begin
               addr_d  = host_addr;
               wdata_d = host_wdata;
               we_d    = host_we;
            end
            SRC_DM: begin
               addr_d  = dm_addr;
               wdata_d = dm_wdata;
               we_d    = dm_we;
            end
            default: begin
               addr_d  = if_addr;
               wdata_d = '0;
               we_d    = 1'b0;
            end
         endcase
      end

      en_d   = launch_c;
      gnt_d  = launch_c ? src_oh(win_c) : 3'b000;
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         src_q     <= SRC_NONE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_data_q <= '0;
         we_q      <= 1'b0;
         en_q      <= 1'b0;
         gnt_q     <= 3'b000;
         rvalid_q  <= 3'b000;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         we_q      <= we_d;
         en_q      <= en_d;
         gnt_q     <= gnt_d;
         rvalid_q  <= rvalid_d;
         busy_q    <= busy_d;
      end
   end

   assign if_gnt      = gnt_q[0];
   assign dm_gnt      = gnt_q[1];
   assign host_gnt    = gnt_q[2];
   assign if_rvalid   = rvalid_q[0];
   assign dm_rvalid   = rvalid_q[1];
   assign host_rvalid = rvalid_q[2];
   assign rd_data     = rd_data_q;
   assign mem_en      = en_q;
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign busy        = busy_q;

endmodule
